// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the SRAM word bridge: FSM states, port
// selector and halfword constants.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    ACK  = 2'd3
  } bridge_state_t;

  typedef enum logic {
    PORT_IF  = 1'b0,
    PORT_MEM = 1'b1
  } port_sel_t;

  localparam logic HALF_LO   = 1'b0;
  localparam logic HALF_HI   = 1'b1;
  localparam int   SRAM_DQ_W = 16;

endpackage

// File: rtl/sram_phase_timer.sv
// Per-phase cycle counter: restarts at zero on start_i and saturates on the
// last cycle of a WAIT_CYCLES-long SRAM phase.
module sram_phase_timer #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic start_i,
  output logic first_o,
  output logic last_o
);

  logic [3:0] cnt_q, cnt_d;

  assign first_o = (cnt_q == 4'd0);
  assign last_o  = (cnt_q == 4'(WAIT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = 4'd0;
    end else if (!last_o) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_word_bridge.sv
// Arbitrates fetch and data word requests onto a 16-bit asynchronous SRAM as
// two halfword phases. Define ARB_ROUND_ROBIN_EN for round-robin arbitration.
module sram_word_bridge
  import mips_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [ADDR_W-1:0]    if_addr,
  output logic [31:0]          if_rdata,
  output logic                 if_ack,
  input  logic                 mem_req,
  input  logic                 mem_we,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [31:0]          mem_wdata,
  output logic [31:0]          mem_rdata,
  output logic                 mem_ack,
  output logic [ADDR_W-1:0]    sram_addr,
  inout  wire  [SRAM_DQ_W-1:0] sram_dq,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic                 sram_ub_n,
  output logic                 sram_lb_n,
  output bridge_state_t        dbg_state
);

  bridge_state_t         state_q, state_d;
  port_sel_t             port_q, grant_port;
  logic                  we_q;
  logic [ADDR_W-2:0]     addr_q;
  logic [31:0]           wdata_q;
  logic [SRAM_DQ_W-1:0]  lo_q;
  logic [31:0]           if_rdata_q, mem_rdata_q;
  logic                  grant, timer_start, ph_first, ph_last, in_phase, half;
  logic                  unused_addr_bits;

  assign unused_addr_bits = if_addr[0] ^ mem_addr[0];
  assign grant            = if_req | mem_req;

`ifdef ARB_ROUND_ROBIN_EN
  // prio_q names the port that wins a tie; it flips away from every granted port.
  port_sel_t prio_q;

  always_comb begin
    grant_port = PORT_IF;
    if (mem_req && if_req) begin
      grant_port = prio_q;
    end else if (mem_req) begin
      grant_port = PORT_MEM;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio_q <= PORT_IF;
    end else if (state_q == IDLE && grant) begin
      prio_q <= (grant_port == PORT_IF) ? PORT_MEM : PORT_IF;
    end
  end
`else
  assign grant_port = mem_req ? PORT_MEM : PORT_IF;
`endif

  assign timer_start = (state_q == IDLE) || (state_q == LO && ph_last);

  sram_phase_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .start_i(timer_start),
    .first_o(ph_first),
    .last_o (ph_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = LO;
      LO:      if (ph_last) state_d = HI;
      HI:      if (ph_last) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read data is captured on the edge that closes each phase.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      port_q      <= PORT_IF;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if (state_q == IDLE && grant) begin
        port_q <= grant_port;
        if (grant_port == PORT_MEM) begin
          addr_q  <= mem_addr[ADDR_W-1:1];
          we_q    <= mem_we;
          wdata_q <= mem_wdata;
        end else begin
          addr_q <= if_addr[ADDR_W-1:1];
          we_q   <= 1'b0;
        end
      end
      if (state_q == LO && ph_last && !we_q) begin
        lo_q <= sram_dq;
      end
      if (state_q == HI && ph_last && !we_q) begin
        if (port_q == PORT_IF) begin
          if_rdata_q <= {sram_dq, lo_q};
        end else begin
          mem_rdata_q <= {sram_dq, lo_q};
        end
      end
    end
  end

  assign in_phase  = (state_q == LO) || (state_q == HI);
  assign half      = (state_q == HI) ? HALF_HI : HALF_LO;

  assign sram_addr = in_phase ? {addr_q, half} : '0;
  assign sram_ce_n = !in_phase;
  assign sram_ub_n = !in_phase;
  assign sram_lb_n = !in_phase;
  assign sram_oe_n = !(in_phase && !we_q);
  // First cycle of a write phase is address setup with we_n still high.
  assign sram_we_n = !(in_phase && we_q && !ph_first);
  assign sram_dq   = (in_phase && we_q) ? (half ? wdata_q[31:16] : wdata_q[15:0])
                                        : {SRAM_DQ_W{1'bz}};

  assign if_ack    = (state_q == ACK) && (port_q == PORT_IF);
  assign mem_ack   = (state_q == ACK) && (port_q == PORT_MEM);
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign dbg_state = state_q;

endmodule
